mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no parameters; memory depth is fixed at 256 words of 19 bits, and the read latency is fixed at 1 cycle.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a_valid  input  1  port A request valid.
REQ-005 a_ready  output  1  port A request accepted this cycle.
REQ-006 a_wr  input  1  port A operation: 1 = write, 0 = read.
REQ-007 a_instr  input  19  port A instruction: [18:10] address field, [9:0] write data.
REQ-008 a_rsp_valid  output  1  port A read-data pulse.
REQ-009 a_rsp_data  output  19  port A read data.
REQ-010 b_valid, b_ready, b_wr, b_instr, b_rsp_valid, b_rsp_data SHALL be port B equivalents of REQ-004..009, with identical widths and directions.
REQ-011 mem_write_enable  output  1  memory write strobe.
REQ-012 mem_read_enable  output  1  memory read strobe.
REQ-013 mem_instr  output  19  instruction presented to the memory.
REQ-014 mem_data_out  input  19  memory registered read data, valid 1 cycle after mem_read_enable.
REQ-015 err  output  1  1-cycle pulse flagging an out-of-range address.
REQ-016 err_port  output  1  port that caused err: 0 = A, 1 = B.

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and RD_WAIT.
REQ-018 Transitions:
- IDLE -> ISSUE when a request is accepted.
- ISSUE -> RD_WAIT for an in-range read.
- ISSUE -> IDLE otherwise.
- RD_WAIT -> IDLE unconditionally.
REQ-019 Acceptance:
- x_ready SHALL be combinational and asserted only in IDLE, for the granted port only.
- At most one ready SHALL be high per cycle.
- Acceptance occurs on any cycle where valid and ready are both high.
REQ-020 Arbitration:
- A single valid port SHALL be granted.
- When both ports are valid, the grant SHALL go to the port not granted most recently.
- The round-robin pointer SHALL update only on acceptance.
REQ-021 On acceptance, the block SHALL latch instr, wr and the owner port.
REQ-022 Valid requests that are not accepted SHALL be held by the requester; the block SHALL never drop them.
REQ-023 In ISSUE, the block SHALL drive registered mem_instr = latched instr for exactly one cycle, with mem_write_enable = wr or mem_read_enable = !wr.
REQ-024 Both enables SHALL never be high together.
REQ-025 Range check: an address with instr[18] = 1 (>= 256) SHALL be out of range; a request with such an address is still accepted.
- In ISSUE, no memory enable SHALL be asserted.
- err SHALL pulse with err_port = owner.
- No response SHALL be issued, even for a read.
REQ-026 In RD_WAIT, the block SHALL capture mem_data_out.
REQ-027 In the following cycle, the owner's rsp_valid SHALL be high for exactly 1 cycle with rsp_data = captured value.
REQ-028 rsp_data SHALL hold its value until the next response to that port.
REQ-029 Latency from accept edge T:
- mem enables high in cycle T+1.
- Read response visible in cycle T+3.
- Next accept no earlier than cycle T+2 (write or out-of-range) or T+3 (read).
REQ-030 A new request MAY be accepted in the same cycle that a previous rsp_valid is high.
REQ-031 The memory enable strobes SHALL be driven only from the latched instr; changes on x_instr after acceptance SHALL have no effect.

Reset
REQ-032 While rst_n = 0, independent of clk, all of the following SHALL apply:
- FSM = IDLE.
- Round-robin pointer favours A.
- All ready, rsp_valid, err, err_port, mem_write_enable and mem_read_enable = 0.
- mem_instr and all rsp_data = 0.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no response and no memory strobe afterwards.
REQ-034 The first grant after reset release SHALL go to port A when both ports are valid.

Verification
REQ-035 A writes 0x0A5 to addr 0x12 -> in cycle T+1, mem_write_enable = 1 and mem_instr = {9'h012, 10'h0A5}; no rsp.
REQ-036 B reads addr 0x12 with memory returning 0x0A5 -> mem_read_enable at T+1; b_rsp_valid = 1 and b_rsp_data = 0x0A5 at T+3; a_rsp_valid stays 0.
REQ-037 A and B valid continuously from reset -> grants alternate A, B, A, B; no port waits more than one grant.
REQ-038 A read with instr[18:10] = 0x100 -> accepted, err = 1 with err_port = 0 at T+1, no memory strobe, no rsp.
REQ-039 rst_n pulled low in RD_WAIT -> all outputs 0 immediately; no rsp_valid after release; next accept lands on A.
REQ-040 Only B valid for 4 requests -> B granted each time, with accepts at 3-cycle spacing for reads and 2-cycle spacing for writes.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin front end for a 256 x 19-bit memory with
// one-cycle registered read latency. One request is in flight at a time:
// IDLE accepts, ISSUE strobes the memory, RD_WAIT captures read data.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  // port A
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_wr,
  input  logic [18:0] a_instr,
  output logic        a_rsp_valid,
  output logic [18:0] a_rsp_data,
  // port B
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_wr,
  input  logic [18:0] b_instr,
  output logic        b_rsp_valid,
  output logic [18:0] b_rsp_data,
  // memory side
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [18:0] mem_instr,
  input  logic [18:0] mem_data_out,
  // error report
  output logic        err,
  output logic        err_port
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // latched request: instr lives in r_mem_instr, which doubles as the
  // registered memory-side instruction during ISSUE
  logic        r_wr;
  logic        r_owner;        // 0 = A, 1 = B
  logic        r_prio_b;       // 1 = B wins the next contested grant

  logic        r_mem_we;
  logic        r_mem_re;
  logic [18:0] r_mem_instr;
  logic        r_err;
  logic        r_err_port;
  logic        r_a_rsp_valid;
  logic        r_b_rsp_valid;
  logic [18:0] r_a_rsp_data;
  logic [18:0] r_b_rsp_data;

  logic        w_accept;
  logic        w_grant_b;
  logic        w_sel_wr;
  logic [18:0] w_sel_instr;
  logic        w_sel_in_range;

  // Addresses occupy instr[18:10]; bit 18 set means >= 256, past the array.
  function automatic logic f_in_range(input logic [18:0] instr);
    return ~instr[18];
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grant selection, acceptance and next-state decode
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_grant_b      = b_valid & (~a_valid | r_prio_b);
    w_sel_wr       = w_grant_b ? b_wr    : a_wr;
    w_sel_instr    = w_grant_b ? b_instr : a_instr;
    w_sel_in_range = f_in_range(w_sel_instr);
    unique case (r_state)
      S_IDLE: begin
        if (a_valid || b_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!r_wr && f_in_range(r_mem_instr)) w_state_nxt = S_RD_WAIT;
        else                                  w_state_nxt = S_IDLE;
      end
      S_RD_WAIT: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is combinational; gating with rst_n keeps it low throughout reset
  assign a_ready = rst_n & w_accept & ~w_grant_b;
  assign b_ready = rst_n & w_accept &  w_grant_b;

  // Round-robin pointer and request ownership, updated only on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_b <= 1'b0;
      r_owner  <= 1'b0;
    end else if (w_accept) begin
      r_prio_b <= ~w_grant_b;
      r_owner  <= w_grant_b;
    end
  end

  // Operation type of the accepted request; meaningful only while busy
  always_ff @(posedge clk) begin
    if (w_accept) r_wr <= w_sel_wr;
  end

  // Memory strobes and instruction, registered at acceptance so they are
  // valid for exactly the ISSUE cycle and immune to later x_instr changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_instr <= '0;
    end else begin
      r_mem_we    <= w_accept &  w_sel_wr & w_sel_in_range;
      r_mem_re    <= w_accept & ~w_sel_wr & w_sel_in_range;
      r_mem_instr <= w_accept ? w_sel_instr : '0;
    end
  end

  // Out-of-range pulse during ISSUE, tagged with the offending port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_port <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_sel_in_range;
      if (w_accept && !w_sel_in_range) r_err_port <= w_grant_b;
    end
  end

  // Read capture at the end of RD_WAIT; the owner's response shows next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rsp_valid <= 1'b0;
      r_b_rsp_valid <= 1'b0;
      r_a_rsp_data  <= '0;
      r_b_rsp_data  <= '0;
    end else begin
      r_a_rsp_valid <= (r_state == S_RD_WAIT) & ~r_owner;
      r_b_rsp_valid <= (r_state == S_RD_WAIT) &  r_owner;
      if (r_state == S_RD_WAIT && !r_owner) r_a_rsp_data <= mem_data_out;
      if (r_state == S_RD_WAIT &&  r_owner) r_b_rsp_data <= mem_data_out;
    end
  end

  assign mem_write_enable = r_mem_we;
  assign mem_read_enable  = r_mem_re;
  assign mem_instr        = r_mem_instr;
  assign err              = r_err;
  assign err_port         = r_err_port;
  assign a_rsp_valid      = r_a_rsp_valid;
  assign b_rsp_valid      = r_b_rsp_valid;
  assign a_rsp_data       = r_a_rsp_data;
  assign b_rsp_data       = r_b_rsp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic on both ports against a
// transaction-timing reference model and a bench-owned memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, a_wr, a_rsp_valid;
  logic [18:0] a_instr, a_rsp_data;
  logic        b_valid, b_ready, b_wr, b_rsp_valid;
  logic [18:0] b_instr, b_rsp_data;
  logic        mem_write_enable, mem_read_enable;
  logic [18:0] mem_instr, mem_data_out;
  logic        err, err_port;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_wr(a_wr), .a_instr(a_instr),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_instr(b_instr),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_instr(mem_instr), .mem_data_out(mem_data_out),
    .err(err), .err_port(err_port)
  );

  typedef struct { bit wr; logic [18:0] instr; } req_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  // reference model state: one transaction in flight, described by when it
  // was accepted and what it was
  int          acc_cyc;
  bit          acc_wr;
  bit          acc_port;
  logic [18:0] acc_instr;
  logic [18:0] acc_rdata;
  bit          prio_b;
  logic [18:0] exp_rsp_a, exp_rsp_b;
  logic [18:0] ref_mem [256];
  logic [18:0] env_mem [256];

  // requesters
  bit          a_pend, b_pend;
  bit          a_rwr, b_rwr;
  logic [18:0] a_rins, b_rins;
  req_t        a_q[$], b_q[$];
  int          rate_a, rate_b, oor_pct;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [18:0] new_instr();
    logic [8:0] addr;
    if ($urandom_range(0, 99) < oor_pct) addr = {1'b1, 8'($urandom)};
    else                                 addr = {1'b0, 8'($urandom_range(0, 15))};
    return {addr, 10'($urandom)};
  endfunction

  task automatic reset_model();
    acc_cyc   = -100;
    acc_wr    = 1'b1;
    acc_port  = 1'b0;
    acc_instr = '0;
    acc_rdata = '0;
    prio_b    = 1'b0;
    exp_rsp_a = '0;
    exp_rsp_b = '0;
  endtask

  task automatic drive_inputs();
    req_t r;
    if (!a_pend) begin
      if (a_q.size() > 0) begin
        r = a_q.pop_front(); a_pend = 1'b1; a_rwr = r.wr; a_rins = r.instr;
      end else if ($urandom_range(0, 99) < rate_a) begin
        a_pend = 1'b1; a_rwr = 1'($urandom_range(0, 1)); a_rins = new_instr();
      end
    end
    if (!b_pend) begin
      if (b_q.size() > 0) begin
        r = b_q.pop_front(); b_pend = 1'b1; b_rwr = r.wr; b_rins = r.instr;
      end else if ($urandom_range(0, 99) < rate_b) begin
        b_pend = 1'b1; b_rwr = 1'($urandom_range(0, 1)); b_rins = new_instr();
      end
    end
    // idle ports present junk so ready must not depend on instr/wr alone
    a_valid = a_pend;
    a_wr    = a_pend ? a_rwr  : 1'($urandom_range(0, 1));
    a_instr = a_pend ? a_rins : 19'($urandom);
    b_valid = b_pend;
    b_wr    = b_pend ? b_rwr  : 1'($urandom_range(0, 1));
    b_instr = b_pend ? b_rins : 19'($urandom);
  endtask

  task automatic check_cycle();
    bit issue, inr, rd_go, rsp_now, free, gb, ea, eb;
    issue   = (cyc == acc_cyc + 1);
    inr     = ~acc_instr[18];
    rd_go   = ~acc_wr & inr;
    rsp_now = (cyc == acc_cyc + 3) & rd_go;
    check_val("mem_we", mem_write_enable, issue & acc_wr & inr);
    check_val("mem_re", mem_read_enable, issue & rd_go);
    if (issue && inr) check_val("mem_instr", mem_instr, acc_instr);
    check_val("err", err, issue & ~inr);
    if (issue && !inr) check_val("err_port", err_port, acc_port);
    if (rsp_now && !acc_port) exp_rsp_a = acc_rdata;
    if (rsp_now &&  acc_port) exp_rsp_b = acc_rdata;
    check_val("a_rsp_valid", a_rsp_valid, rsp_now & ~acc_port);
    check_val("b_rsp_valid", b_rsp_valid, rsp_now &  acc_port);
    check_val("a_rsp_data", a_rsp_data, exp_rsp_a);
    check_val("b_rsp_data", b_rsp_data, exp_rsp_b);
    // busy for 2 cycles after a write/out-of-range accept, 3 after a read
    free = (cyc >= acc_cyc + (rd_go ? 3 : 2));
    gb   = b_valid & (~a_valid | prio_b);
    ea   = free & a_valid & ~gb;
    eb   = free & gb;
    check_val("a_ready", a_ready, ea);
    check_val("b_ready", b_ready, eb);
    if (ea || eb) begin
      acc_cyc   = cyc;
      acc_port  = eb;
      acc_wr    = eb ? b_rwr  : a_rwr;
      acc_instr = eb ? b_rins : a_rins;
      prio_b    = ~eb;
      if (eb) b_pend = 1'b0; else a_pend = 1'b0;
      if (!acc_instr[18]) begin
        if (acc_wr) ref_mem[acc_instr[17:10]] = {9'd0, acc_instr[9:0]};
        else        acc_rdata = ref_mem[acc_instr[17:10]];
      end
    end
  endtask

  // one clock: memory reacts to this cycle's strobes, then new inputs, then checks
  task automatic cycle_step();
    bit          we, re;
    logic [18:0] mi;
    we = mem_write_enable;
    re = mem_read_enable;
    mi = mem_instr;
    @(posedge clk);
    #1;
    cyc++;
    if (re) mem_data_out = env_mem[mi[17:10]];
    if (we) env_mem[mi[17:10]] = {9'd0, mi[9:0]};
    drive_inputs();
    #1;
    check_cycle();
  endtask

  task automatic check_reset_outputs();
    check_val("rst_a_ready", a_ready, 0);
    check_val("rst_b_ready", b_ready, 0);
    check_val("rst_a_rsp_valid", a_rsp_valid, 0);
    check_val("rst_b_rsp_valid", b_rsp_valid, 0);
    check_val("rst_a_rsp_data", a_rsp_data, 0);
    check_val("rst_b_rsp_data", b_rsp_data, 0);
    check_val("rst_err", err, 0);
    check_val("rst_err_port", err_port, 0);
    check_val("rst_mem_we", mem_write_enable, 0);
    check_val("rst_mem_re", mem_read_enable, 0);
    check_val("rst_mem_instr", mem_instr, 0);
  endtask

  // release reset just after an edge so the first post-reset cycle is modelled
  task automatic do_release();
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc++;
    mem_data_out = '0;
    rst_n = 1'b1;
    reset_model();
    drive_inputs();
    #1;
    check_cycle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((a_pend || b_pend || a_q.size() > 0 || b_q.size() > 0) && n < 200) begin
      cycle_step();
      n++;
    end
    check_val("drain_timeout", (n < 200), 1);
    for (int i = 0; i < 4; i++) cycle_step();
  endtask

  initial begin
    req_t r;
    int   n;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = {9'd0, 10'($urandom)};
      env_mem[i] = ref_mem[i];
    end
    rst_n = 1'b0; a_pend = 1'b0; b_pend = 1'b0;
    a_rwr = 1'b0; b_rwr = 1'b0; a_rins = '0; b_rins = '0;
    mem_data_out = '0;
    a_valid = 1'b1; a_wr = 1'b0; a_instr = 19'h12345;
    b_valid = 1'b1; b_wr = 1'b1; b_instr = 19'h54321;
    reset_model();
    #3;
    check_reset_outputs();

    // both ports saturated from reset: A first, then strict alternation
    rate_a = 100; rate_b = 100; oor_pct = 10;
    do_release();
    check_val("first_grant_a", acc_port, 0);
    for (int i = 0; i < 30; i++) cycle_step();

    // directed write, read-back from B, and out-of-range read from A
    rate_a = 0; rate_b = 0;
    drain();
    r.wr = 1'b1; r.instr = {9'h012, 10'h0A5}; a_q.push_back(r);
    drain();
    r.wr = 1'b0; r.instr = {9'h012, 10'h3FF}; b_q.push_back(r);
    drain();
    check_val("b_readback", b_rsp_data, 19'h000A5);
    r.wr = 1'b0; r.instr = {9'h100, 10'h000}; a_q.push_back(r);
    drain();

    // B alone: read, write, read, write back to back
    for (int i = 0; i < 4; i++) begin
      r.wr = 1'(i & 1); r.instr = {9'(i + 3), 10'($urandom)}; b_q.push_back(r);
    end
    drain();

    // random traffic
    rate_a = 60; rate_b = 60; oor_pct = 15;
    for (int i = 0; i < 2000; i++) cycle_step();

    // reset while an A read is waiting for memory data
    rate_a = 0; rate_b = 0;
    drain();
    r.wr = 1'b0; r.instr = {9'h005, 10'h000}; a_q.push_back(r);
    n = 0;
    do begin
      cycle_step();
      n++;
    end while (!(cyc == acc_cyc + 2 && acc_port == 1'b0 && !acc_wr) && n < 50);
    check_val("reach_rd_wait", (n < 50), 1);
    a_pend = 1'b1; a_rwr = 1'b0; a_rins = {9'h006, 10'h000};
    b_pend = 1'b1; b_rwr = 1'b1; b_rins = {9'h007, 10'h155};
    a_valid = 1'b1; a_wr = a_rwr; a_instr = a_rins;
    b_valid = 1'b1; b_wr = b_rwr; b_instr = b_rins;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    do_release();
    check_val("post_reset_grant_a", acc_port, 0);
    for (int i = 0; i < 10; i++) cycle_step();

    rate_a = 50; rate_b = 70; oor_pct = 10;
    for (int i = 0; i < 300; i++) cycle_step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
